// File: rtl/mem_stall_ctrl.sv
// MEM-stage load/store controller: stalls the pipeline while a single aligned
// access is carried over a simple ready-handshake bus, with a bounded wait.
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_out,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        misalign_out,
  output logic        err_out,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [31:0]      rdata_q;

  logic             aligned;
  logic             latch_en;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             resp_ok;
  logic             resp_to;
  logic             in_req;
  logic [31:0]      lane;
  logic [31:0]      load_ext;
  logic [3:0]       strb;
  logic [31:0]      wdata_rep;

  always_comb begin
    unique case (req_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Load lane selection and extension from the latched size/offset
  always_comb begin
    lane = bus_rdata >> {addr_q[1:0], 3'b000};
    unique case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    unique case (size_q)
      2'b00: begin
        strb      = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strb      = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        strb      = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall_out    = 1'b0;
    misalign_out = 1'b0;
    latch_en     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    resp_ok      = 1'b0;
    resp_to      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (aligned) begin
            stall_out = 1'b1;
            latch_en  = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            misalign_out = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_out = 1'b1;
        if (bus_ready) begin
          resp_ok   = 1'b1;
          state_nxt = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_to   = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      if (latch_en) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      err_q <= resp_to;
      if (resp_to)                rdata_q <= 32'd0;
      else if (resp_ok && !we_q)  rdata_q <= load_ext;
    end
  end

  // Bus and response outputs decode the registered state and latched request
  always_comb begin
    in_req      = (state == ST_REQ);
    bus_req     = in_req;
    bus_we      = in_req & we_q;
    bus_addr    = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    bus_wstrb   = (in_req && we_q) ? strb : 4'b0000;
    bus_wdata   = in_req ? wdata_rep : 32'd0;
    rdata_valid = (state == ST_RESP) & ~we_q;
    err_out     = (state == ST_RESP) & err_q;
    rdata_out   = rdata_q;
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl: driver pushes expected responses,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_mem_stall_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall_out, rdata_valid, misalign_out, err_out;
  logic [31:0] rdata_out;
  logic        bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  mem_stall_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall_out(stall_out), .rdata_out(rdata_out),
    .rdata_valid(rdata_valid), .misalign_out(misalign_out), .err_out(err_out),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mis;
    bit          we;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          stall;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          seen_req = 1'b0;
  int          stall_cnt = 0;
  logic [31:0] last_rdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-lane view of the access
  function automatic exp_t model(input bit we, input logic [1:0] size, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int d);
    exp_t e;
    int off, n;
    logic [31:0] res, mask;
    off = int'(addr[1:0]);
    n = 1 << size;
    e.mis = (size == 2'b11) || (off % n != 0);
    e.we = we;
    e.addr = addr & 32'hFFFF_FFFC;
    e.err = (d >= int'(TO));
    e.stall = e.err ? 1 + int'(TO) : d + 2;
    e.wstrb = 4'b0000;
    e.wdata = 32'd0;
    res = 32'd0;
    for (int i = 0; i < 4; i++) begin
      e.wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
      if (we && i >= off && i < off + n) e.wstrb[i] = 1'b1;
    end
    if (!e.mis) begin
      for (int i = 0; i < n; i++) res[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (n < 4 && !uns) begin
        mask = (32'h1 << (8*n)) - 32'h1;
        if (res[8*n-1]) res = res | ~mask;
      end
    end
    e.rdata = res;
    return e;
  endfunction

  // Drives one access starting in an IDLE cycle; d = REQ cycle index carrying bus_ready
  task automatic do_txn(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int d);
    exp_t e;
    int nreq;
    e = model(we, size, uns, addr, wdata, rdata, d);
    q.push_back(e);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    bus_ready = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    if (e.mis) begin
      @(posedge clk); #1;
      req_valid = 1'b0; bus_ready = 1'b0;
      return;
    end
    nreq = (d < int'(TO)) ? d + 1 : int'(TO);
    for (int k = 0; k < nreq; k++) begin
      @(posedge clk); #1;
      bus_ready = (k == d);
      bus_rdata = (k == d) ? rdata : $urandom;
    end
    @(posedge clk); #1;
    req_valid = 1'($urandom_range(0, 1));
    req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_addr = $urandom; req_wdata = $urandom;
    bus_ready = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen_req = 1'b0; stall_cnt = 0; last_rdata = 32'd0;
    end else if (mon_en) begin
      if (stall_out) stall_cnt++;
      if (misalign_out) begin
        if (q.size() == 0) chk("misalign_unexpected", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("misalign_expected", 32'(e.mis), 32'd1);
          chk("misalign_bus_req", 32'(bus_req), 32'd0);
          chk("misalign_stall", 32'(stall_out), 32'd0);
        end
      end
      if (bus_req) begin
        if (q.size() == 0) chk("bus_req_unexpected", 32'd1, 32'd0);
        else begin
          e = q[0];
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_we", 32'(bus_we), 32'(e.we));
          chk("bus_wstrb", 32'(bus_wstrb), 32'(e.wstrb));
          if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
          chk("req_stall", 32'(stall_out), 32'd1);
        end
        seen_req = 1'b1;
      end else if (seen_req) begin
        seen_req = 1'b0;
        if (q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          if (e.err) last_rdata = 32'd0;
          else if (!e.we) last_rdata = e.rdata;
          chk("rdata_valid", 32'(rdata_valid), 32'(!e.we));
          chk("err_out", 32'(err_out), 32'(e.err));
          chk("rdata_out", rdata_out, last_rdata);
          chk("resp_stall", 32'(stall_out), 32'd0);
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
        end
        stall_cnt = 0;
      end else begin
        chk("idle_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("idle_err_out", 32'(err_out), 32'd0);
        chk("idle_rdata_hold", rdata_out, last_rdata);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_bus_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_wstrb"}, 32'(bus_wstrb), 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
    chk({tag, "_err"}, 32'(err_out), 32'd0);
    chk({tag, "_misalign"}, 32'(misalign_out), 32'd0);
    chk({tag, "_rdata"}, rdata_out, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    bus_ready = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    mon_en = 1'b1;

    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 0);
    do_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 32'h8011_2233, 0);
    do_txn(1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'd0, 32'h8011_2233, 1);
    do_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'd0, 32'd0, 0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'd0, 32'h1234_5678, 9);
    do_txn(1'b0, 2'b01, 1'b0, 32'h0000_3000, 32'd0, 32'h0000_F00F, 3);
    do_txn(1'b1, 2'b11, 1'b0, 32'h0000_3000, 32'd0, 32'd0, 0);

    for (int t = 0; t < 200; t++) begin
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    // Reset mid-access: abandon the load, ignore a late bus_ready
    mon_en = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_4000; bus_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk_all_zero("rst_mid");
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_after");
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_txn(1'b0, 2'b00, 1'b1, 32'h0000_5001, 32'd0, 32'h00A5_0000, 0);
    do_txn(1'b0, 2'b00, 1'b1, 32'h0000_5002, 32'd0, 32'h00A5_0000, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("final_queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
